// File: rtl/victim_buffer_pkg.sv
// Shared cache types: CPU scalar types, victim-buffer query bus payloads and label width helper.
package victim_buffer_pkg;

   typedef logic [31:0] phys_t;
   typedef logic [7:0]  uint8_t;

   localparam int unsigned PHYS_WIDTH = $bits(phys_t);

   // Label keeps the physical address bits above the in-line byte offset.
   function automatic int unsigned label_width(input int unsigned line_width);
      return PHYS_WIDTH - 32'($clog2(line_width / 8));
   endfunction

   localparam int unsigned VB_LINE_WIDTH  = 256;
   localparam int unsigned VB_BE_WIDTH    = VB_LINE_WIDTH / 8;
   localparam int unsigned VB_LABEL_WIDTH = label_width(VB_LINE_WIDTH);

   typedef struct packed {
      logic [VB_LABEL_WIDTH-1:0] label;
      logic                      write;
      logic [VB_BE_WIDTH-1:0]    wbe;
      logic [VB_LINE_WIDTH-1:0]  wdata;
      logic                      take;
   } victim_query_req_t;

   typedef struct packed {
      logic                      found;
      logic [VB_LINE_WIDTH-1:0]  rdata;
      logic                      written;
      logic                      taken;
   } victim_query_resp_t;

endpackage

// File: rtl/victim_buffer_match.sv
// Label comparator across all valid victim entries: one-hot hit, encoded index and found flag.
module victim_buffer_match
   import victim_buffer_pkg::*;
#(
   parameter int unsigned  LABEL_WIDTH = 27,
   parameter int unsigned  LINE_DEPTH  = 8,
   localparam int unsigned IDX_WIDTH   = $clog2(LINE_DEPTH)
) (
   input  logic [LABEL_WIDTH-1:0] label,
   input  logic [LINE_DEPTH-1:0]  valid,
   input  logic [LABEL_WIDTH-1:0] labels [LINE_DEPTH],
   output logic [LINE_DEPTH-1:0]  hit,
   output logic [IDX_WIDTH-1:0]   idx,
   output logic                   found
);

   always_comb begin
      hit = '0;
      idx = '0;
      for (int unsigned i = 0; i < LINE_DEPTH; i++) begin
         hit[i] = valid[i] && (labels[i] == label);
         if (hit[i]) idx = IDX_WIDTH'(i);
      end
      found = |hit;
   end

endmodule

// File: rtl/victim_buffer.sv
// Victim buffer: ring of evicted lines with merge-on-push, per-port lookup/write/take and in-order drain.
module victim_buffer
   import victim_buffer_pkg::*;
#(
   parameter int unsigned  LINE_WIDTH  = 256,
   parameter int unsigned  LINE_DEPTH  = 8,
   parameter int unsigned  N_PORTS     = 2,
   localparam int unsigned BE_WIDTH    = LINE_WIDTH / 8,
   localparam int unsigned LABEL_WIDTH = label_width(LINE_WIDTH),
   localparam int unsigned ENTRY_WIDTH = LABEL_WIDTH + LINE_WIDTH,
   localparam int unsigned IDX_WIDTH   = $clog2(LINE_DEPTH),
   localparam int unsigned CNT_WIDTH   = IDX_WIDTH + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_valid,
   output logic                   push_ready,
   input  logic [ENTRY_WIDTH-1:0] push_line,
   input  logic [BE_WIDTH-1:0]    push_be,
   output logic                   pop_valid,
   input  logic                   pop_ready,
   output logic [ENTRY_WIDTH-1:0] pop_line,
   input  logic [LABEL_WIDTH-1:0] q_label [N_PORTS],
   output logic [N_PORTS-1:0]     q_found,
   output logic [LINE_WIDTH-1:0]  q_rdata [N_PORTS],
   input  logic [N_PORTS-1:0]     q_write,
   input  logic [BE_WIDTH-1:0]    q_wbe   [N_PORTS],
   input  logic [LINE_WIDTH-1:0]  q_wdata [N_PORTS],
   output logic [N_PORTS-1:0]     q_written,
   input  logic [N_PORTS-1:0]     q_take,
   output logic [N_PORTS-1:0]     q_taken,
   output logic [CNT_WIDTH-1:0]   count
);

   logic [LINE_DEPTH-1:0]  valid, valid_next, take_vec;
   logic [LABEL_WIDTH-1:0] lbl  [LINE_DEPTH];
   logic [LINE_WIDTH-1:0]  data [LINE_DEPTH];
   logic [IDX_WIDTH-1:0]   head, head_next, tail, tail_next;
   logic [CNT_WIDTH-1:0]   count_next, take_cnt;

   logic [LINE_DEPTH-1:0]  q_hit [N_PORTS];
   logic [IDX_WIDTH-1:0]   q_idx [N_PORTS];
   logic [LINE_DEPTH-1:0]  push_hit;
   logic [IDX_WIDTH-1:0]   push_idx;
   logic                   push_found;

   logic                   pop_fire, merge_hit, push_fire, do_merge, do_alloc;
   logic [LABEL_WIDTH-1:0] push_label;
   logic [LINE_WIDTH-1:0]  push_data, push_mask;

   assign push_label = push_line[ENTRY_WIDTH-1 -: LABEL_WIDTH];
   assign push_data  = push_line[LINE_WIDTH-1:0];

   for (genvar p = 0; p < N_PORTS; p++) begin : g_query
      victim_buffer_match #(.LABEL_WIDTH(LABEL_WIDTH), .LINE_DEPTH(LINE_DEPTH)) u_match (
         .label  (q_label[p]),
         .valid  (valid),
         .labels (lbl),
         .hit    (q_hit[p]),
         .idx    (q_idx[p]),
         .found  (q_found[p])
      );
   end

   victim_buffer_match #(.LABEL_WIDTH(LABEL_WIDTH), .LINE_DEPTH(LINE_DEPTH)) u_push_match (
      .label  (push_label),
      .valid  (valid),
      .labels (lbl),
      .hit    (push_hit),
      .idx    (push_idx),
      .found  (push_found)
   );

   // Read side: every data output is masked by a valid bit.
   always_comb begin
      pop_valid = valid[head];
      pop_line  = pop_valid ? {lbl[head], data[head]} : '0;
      for (int unsigned p = 0; p < N_PORTS; p++) begin
         q_rdata[p] = q_found[p] ? data[q_idx[p]] : '0;
      end
   end

   // Arbitration of pop, takes (lowest port wins), writes and push merge/allocate.
   always_comb begin
      pop_fire  = valid[head] & pop_ready;
      take_vec  = '0;
      q_taken   = '0;
      q_written = '0;
      take_cnt  = '0;
      push_mask = '0;
      for (int unsigned p = 0; p < N_PORTS; p++) begin
         if (q_take[p] && q_found[p] && !(pop_fire && q_idx[p] == head) && !take_vec[q_idx[p]]) begin
            q_taken[p] = 1'b1;
            take_vec   = take_vec | q_hit[p];
         end
      end
      for (int unsigned p = 0; p < N_PORTS; p++) begin
         q_written[p] = q_write[p] && q_found[p] && !(pop_fire && q_idx[p] == head)
                        && !take_vec[q_idx[p]];
      end
      for (int unsigned i = 0; i < LINE_DEPTH; i++) begin
         take_cnt = take_cnt + CNT_WIDTH'(take_vec[i]);
      end
      for (int unsigned b = 0; b < BE_WIDTH; b++) begin
         push_mask[b*8 +: 8] = {8{push_be[b]}};
      end
      merge_hit  = push_found && !(pop_fire && push_hit[head]) && !(|(push_hit & take_vec));
      push_ready = merge_hit || !valid[tail] || (pop_fire && tail == head);
      push_fire  = push_valid && push_ready;
      do_merge   = push_fire && merge_hit;
      do_alloc   = push_fire && !merge_hit;

      valid_next = valid & ~take_vec;
      if (pop_fire) valid_next[head] = 1'b0;
      if (do_alloc) valid_next[tail] = 1'b1;
      // Head also walks over holes left by takes while anything is still stored.
      head_next  = (pop_fire || (!valid[head] && count != '0)) ? head + IDX_WIDTH'(1) : head;
      tail_next  = do_alloc ? tail + IDX_WIDTH'(1) : tail;
      count_next = count + CNT_WIDTH'(do_alloc) - CNT_WIDTH'(pop_fire) - take_cnt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         valid <= valid_next;
         head  <= head_next;
         tail  <= tail_next;
         count <= count_next;
      end
   end

   // Entry payload; later byte assignments win, giving merge-then-port-order priority.
   always_ff @(posedge clk) begin
      if (do_alloc) begin
         lbl[tail]  <= push_label;
         data[tail] <= push_data & push_mask;
      end
      for (int unsigned b = 0; b < BE_WIDTH; b++) begin
         if (do_merge && push_be[b]) data[push_idx][b*8 +: 8] <= push_data[b*8 +: 8];
      end
      for (int unsigned p = 0; p < N_PORTS; p++) begin
         for (int unsigned b = 0; b < BE_WIDTH; b++) begin
            if (q_written[p] && q_wbe[p][b]) data[q_idx[p]][b*8 +: 8] <= q_wdata[p][b*8 +: 8];
         end
      end
   end

endmodule

// File: tb/tb_victim_buffer.sv
// Self-checking bench for victim_buffer: directed scenarios plus randomized run against a slot model.
module tb_victim_buffer;

   localparam int LW  = 256;
   localparam int D   = 8;
   localparam int NP  = 2;
   localparam int BE  = LW / 8;
   localparam int LBW = 27;
   localparam int EW  = LBW + LW;
   localparam logic [LBW-1:0] LA   = 27'h100;
   localparam logic [LBW-1:0] POOL = 27'h40;

   logic            clk = 1'b0;
   logic            rst;
   logic            push_valid, push_ready;
   logic [EW-1:0]   push_line;
   logic [BE-1:0]   push_be;
   logic            pop_valid, pop_ready;
   logic [EW-1:0]   pop_line;
   logic [LBW-1:0]  q_label [NP];
   logic [NP-1:0]   q_found;
   logic [LW-1:0]   q_rdata [NP];
   logic [NP-1:0]   q_write;
   logic [BE-1:0]   q_wbe   [NP];
   logic [LW-1:0]   q_wdata [NP];
   logic [NP-1:0]   q_written;
   logic [NP-1:0]   q_take, q_taken;
   logic [3:0]      count;

   int checks = 0;
   int errors = 0;

   // Reference model: slot contents and ring pointers.
   logic            m_valid [D];
   logic [LBW-1:0]  m_label [D];
   logic [LW-1:0]   m_data  [D];
   int              m_head, m_tail;

   victim_buffer #(.LINE_WIDTH(LW), .LINE_DEPTH(D), .N_PORTS(NP)) dut (
      .clk(clk), .rst(rst),
      .push_valid(push_valid), .push_ready(push_ready), .push_line(push_line), .push_be(push_be),
      .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_line(pop_line),
      .q_label(q_label), .q_found(q_found), .q_rdata(q_rdata),
      .q_write(q_write), .q_wbe(q_wbe), .q_wdata(q_wdata), .q_written(q_written),
      .q_take(q_take), .q_taken(q_taken), .count(count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [LW-1:0] rnd_data();
      logic [LW-1:0] r;
      for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [LW-1:0] be_mask(input logic [BE-1:0] be);
      logic [LW-1:0] r;
      for (int b = 0; b < BE; b++) r[b*8 +: 8] = {8{be[b]}};
      return r;
   endfunction

   function automatic int m_find(input logic [LBW-1:0] l);
      for (int i = 0; i < D; i++) if (m_valid[i] && m_label[i] == l) return i;
      return -1;
   endfunction

   task automatic idle();
      push_valid = 1'b0; push_line = '0; push_be = '0; pop_ready = 1'b0;
      q_write = '0; q_take = '0;
      for (int p = 0; p < NP; p++) begin
         q_label[p] = '0; q_wbe[p] = '0; q_wdata[p] = '0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic drive_push(input logic [LBW-1:0] l, input logic [LW-1:0] d, input logic [BE-1:0] be);
      push_valid = 1'b1; push_line = {l, d}; push_be = be;
   endtask

   task automatic test_reset();
      do_reset();
      q_write = '1; q_take = '1;
      #1;
      checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count act=%0d exp=0", count); end
      checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL reset_pop_valid act=%b exp=0", pop_valid); end
      checks++; if (pop_line !== '0) begin errors++; $display("FAIL reset_pop_line act=%h exp=0", pop_line); end
      checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL reset_push_ready act=%b exp=1", push_ready); end
      checks++; if (q_found !== 2'b00) begin errors++; $display("FAIL reset_q_found act=%b exp=00", q_found); end
      checks++; if (q_written !== 2'b00 || q_taken !== 2'b00)
         begin errors++; $display("FAIL reset_wr_tk act=%b/%b exp=00/00", q_written, q_taken); end
      idle();
   endtask

   task automatic test_fill();
      do_reset();
      for (int i = 0; i < D; i++) begin
         drive_push(LBW'(LA + i), rnd_data(), '1);
         #1;
         checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d act=%b exp=1", i, push_ready); end
         tick();
      end
      drive_push(LBW'(LA + 8), rnd_data(), '1);
      #1;
      checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL full_ready act=%b exp=0", push_ready); end
      checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count act=%0d exp=8", count); end
      pop_ready = 1'b1;
      #1;
      checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL full_pop_push_ready act=%b exp=1", push_ready); end
      checks++; if (pop_line[EW-1 -: LBW] !== LA) begin errors++; $display("FAIL full_pop_label act=%h exp=%h", pop_line[EW-1 -: LBW], LA); end
      tick();
      idle();
      q_label[0] = LBW'(LA + 8);
      #1;
      checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_swap_count act=%0d exp=8", count); end
      checks++; if (pop_line[EW-1 -: LBW] !== LBW'(LA + 1)) begin errors++; $display("FAIL full_next_label act=%h exp=%h", pop_line[EW-1 -: LBW], LBW'(LA + 1)); end
      checks++; if (q_found[0] !== 1'b1) begin errors++; $display("FAIL full_found_i act=%b exp=1", q_found[0]); end
      idle();
   endtask

   task automatic test_take_skip();
      logic [LW-1:0] da;
      da = rnd_data();
      do_reset();
      drive_push(LA, da, '1); tick();
      drive_push(LBW'(LA + 1), rnd_data(), '1); tick();
      idle();
      q_label[0] = LA; q_take[0] = 1'b1;
      #1;
      checks++; if (q_taken !== 2'b01) begin errors++; $display("FAIL take_ack act=%b exp=01", q_taken); end
      checks++; if (q_rdata[0] !== da) begin errors++; $display("FAIL take_rdata act=%h exp=%h", q_rdata[0], da); end
      tick();
      idle();
      #1;
      checks++; if (count !== 4'd1) begin errors++; $display("FAIL take_count act=%0d exp=1", count); end
      tick();
      checks++; if (pop_valid !== 1'b1 || pop_line[EW-1 -: LBW] !== LBW'(LA + 1))
         begin errors++; $display("FAIL take_skip act=%b/%h exp=1/%h", pop_valid, pop_line[EW-1 -: LBW], LBW'(LA + 1)); end
   endtask

   task automatic test_merge();
      logic [LW-1:0] d;
      do_reset();
      drive_push(LA, '0, '1); tick();
      d = rnd_data();
      d[7:0] = 8'h5A;
      drive_push(LA, d, 32'h1);
      #1;
      checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL merge_ready act=%b exp=1", push_ready); end
      tick();
      idle();
      q_label[0] = LA;
      #1;
      checks++; if (count !== 4'd1) begin errors++; $display("FAIL merge_count act=%0d exp=1", count); end
      checks++; if (q_rdata[0] !== 256'h5A) begin errors++; $display("FAIL merge_rdata act=%h exp=5a", q_rdata[0]); end
   endtask

   task automatic test_dual_write();
      logic [LW-1:0] d, e;
      d = rnd_data();
      do_reset();
      drive_push(LA, d, '1); tick();
      idle();
      for (int p = 0; p < NP; p++) begin
         q_label[p] = LA; q_wbe[p] = 32'h1; q_wdata[p] = rnd_data();
      end
      q_wdata[0][7:0] = 8'h11; q_wdata[1][7:0] = 8'h22; q_write = 2'b11;
      #1;
      checks++; if (q_written !== 2'b11) begin errors++; $display("FAIL dual_written act=%b exp=11", q_written); end
      tick();
      idle();
      q_label[0] = LA;
      e = {d[LW-1:8], 8'h22};
      #1;
      checks++; if (q_rdata[0] !== e) begin errors++; $display("FAIL dual_data act=%h exp=%h", q_rdata[0], e); end
   endtask

   task automatic test_pop_write();
      logic [LW-1:0] d;
      d = rnd_data();
      do_reset();
      drive_push(LA, d, '1); tick();
      idle();
      pop_ready = 1'b1; q_label[0] = LA; q_write[0] = 1'b1; q_wbe[0] = '1; q_wdata[0] = ~d;
      #1;
      checks++; if (q_written[0] !== 1'b0) begin errors++; $display("FAIL popwr_written act=%b exp=0", q_written[0]); end
      checks++; if (pop_line !== {LA, d}) begin errors++; $display("FAIL popwr_line act=%h exp=%h", pop_line, {LA, d}); end
      tick();
      idle();
      #1;
      checks++; if (count !== 4'd0) begin errors++; $display("FAIL popwr_count act=%0d exp=0", count); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 3; i++) begin drive_push(LBW'(LA + i), rnd_data(), '1); tick(); end
      drive_push(LBW'(LA + 3), rnd_data(), '1);
      pop_ready = 1'b1; rst = 1'b1;
      tick();
      rst = 1'b0;
      idle();
      q_label[0] = LA; q_label[1] = LBW'(LA + 1);
      #1;
      checks++; if (count !== 4'd0) begin errors++; $display("FAIL rstmid_count act=%0d exp=0", count); end
      checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL rstmid_pop_valid act=%b exp=0", pop_valid); end
      checks++; if (q_found !== 2'b00) begin errors++; $display("FAIL rstmid_found act=%b exp=00", q_found); end
      q_label[0] = LBW'(LA + 2); q_label[1] = LBW'(LA + 3);
      #1;
      checks++; if (q_found !== 2'b00) begin errors++; $display("FAIL rstmid_found2 act=%b exp=00", q_found); end
   endtask

   task automatic test_random();
      int             s [NP];
      logic           tk [D];
      logic           e_pv, popped, merge, e_ready;
      logic [EW-1:0]  e_pl;
      logic [NP-1:0]  e_found, e_taken, e_written;
      logic [LW-1:0]  e_rdata [NP];
      logic [LBW-1:0] pl;
      logic [LW-1:0]  pd;
      int             ps, n_valid;
      do_reset();
      for (int i = 0; i < D; i++) m_valid[i] = 1'b0;
      m_head = 0; m_tail = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         rst        = ($urandom_range(0, 99) == 0);
         push_valid = ($urandom_range(0, 3) != 0);
         push_line  = {LBW'(POOL + $urandom_range(0, 11)), rnd_data()};
         push_be    = $urandom;
         pop_ready  = ($urandom_range(0, 2) == 0);
         for (int p = 0; p < NP; p++) begin
            q_label[p] = LBW'(POOL + $urandom_range(0, 11));
            q_write[p] = ($urandom_range(0, 3) == 0);
            q_take[p]  = ($urandom_range(0, 5) == 0);
            q_wbe[p]   = $urandom;
            q_wdata[p] = rnd_data();
         end
         #1;
         pl = push_line[EW-1 -: LBW];
         pd = push_line[LW-1:0];
         n_valid = 0;
         for (int i = 0; i < D; i++) begin n_valid += int'(m_valid[i]); tk[i] = 1'b0; end
         e_pv   = m_valid[m_head];
         e_pl   = e_pv ? {m_label[m_head], m_data[m_head]} : '0;
         popped = e_pv && pop_ready;
         e_taken = '0;
         for (int p = 0; p < NP; p++) begin
            s[p]       = m_find(q_label[p]);
            e_found[p] = (s[p] >= 0);
            e_rdata[p] = (s[p] >= 0) ? m_data[s[p]] : '0;
         end
         for (int p = 0; p < NP; p++) begin
            if (q_take[p] && s[p] >= 0) begin
               if (!(popped && s[p] == m_head) && !tk[s[p]]) begin e_taken[p] = 1'b1; tk[s[p]] = 1'b1; end
            end
         end
         for (int p = 0; p < NP; p++) begin
            e_written[p] = 1'b0;
            if (q_write[p] && s[p] >= 0) e_written[p] = !(popped && s[p] == m_head) && !tk[s[p]];
         end
         ps = m_find(pl);
         merge = 1'b0;
         if (ps >= 0) merge = !(popped && ps == m_head) && !tk[ps];
         e_ready = merge || !m_valid[m_tail] || (popped && m_tail == m_head);

         checks++; if (count !== 4'(n_valid)) begin errors++; $display("FAIL rnd_count cyc=%0d act=%0d exp=%0d", cyc, count, n_valid); end
         checks++; if (pop_valid !== e_pv) begin errors++; $display("FAIL rnd_pop_valid cyc=%0d act=%b exp=%b", cyc, pop_valid, e_pv); end
         checks++; if (pop_line !== e_pl) begin errors++; $display("FAIL rnd_pop_line cyc=%0d act=%h exp=%h", cyc, pop_line, e_pl); end
         checks++; if (push_ready !== e_ready) begin errors++; $display("FAIL rnd_push_ready cyc=%0d act=%b exp=%b", cyc, push_ready, e_ready); end
         checks++; if (q_found !== e_found) begin errors++; $display("FAIL rnd_found cyc=%0d act=%b exp=%b", cyc, q_found, e_found); end
         checks++; if (q_taken !== e_taken) begin errors++; $display("FAIL rnd_taken cyc=%0d act=%b exp=%b", cyc, q_taken, e_taken); end
         checks++; if (q_written !== e_written) begin errors++; $display("FAIL rnd_written cyc=%0d act=%b exp=%b", cyc, q_written, e_written); end
         for (int p = 0; p < NP; p++) begin
            checks++; if (q_rdata[p] !== e_rdata[p]) begin errors++; $display("FAIL rnd_rdata%0d cyc=%0d act=%h exp=%h", p, cyc, q_rdata[p], e_rdata[p]); end
         end

         tick();
         if (rst) begin
            for (int i = 0; i < D; i++) m_valid[i] = 1'b0;
            m_head = 0; m_tail = 0;
         end else begin
            if (push_valid && merge)
               m_data[ps] = (m_data[ps] & ~be_mask(push_be)) | (pd & be_mask(push_be));
            for (int p = 0; p < NP; p++)
               if (e_written[p]) m_data[s[p]] = (m_data[s[p]] & ~be_mask(q_wbe[p])) | (q_wdata[p] & be_mask(q_wbe[p]));
            for (int i = 0; i < D; i++) if (tk[i]) m_valid[i] = 1'b0;
            if (popped) m_valid[m_head] = 1'b0;
            if (push_valid && e_ready && !merge) begin
               m_label[m_tail] = pl;
               m_data[m_tail]  = pd & be_mask(push_be);
               m_valid[m_tail] = 1'b1;
               m_tail = (m_tail + 1) % D;
            end
            if (popped || (!e_pv && n_valid != 0)) m_head = (m_head + 1) % D;
         end
      end
      rst = 1'b0;
      idle();
   endtask

   initial begin
      rst = 1'b1;
      idle();
      test_reset();
      test_fill();
      test_take_skip();
      test_merge();
      test_dual_write();
      test_pop_write();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
